// File: rtl/avst_gen_pack.sv
// rtl/avst_gen_pack.sv - shared Avalon-ST generator/checker constants, FSM state type and pattern function
package avst_gen_pack;

    localparam int SYMBOL_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } gen_state_e;

    // Byte at offset b of packet p; the sink checker regenerates the same sequence.
    function automatic logic [SYMBOL_WIDTH-1:0] pattern_byte(input logic [31:0] p, input logic [31:0] b);
        return SYMBOL_WIDTH'(p + b);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// rtl/avalon_st_if.sv - Avalon-ST valid/ready packet interface with sop/eop/empty framing
interface avalon_st_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int SYMBOLS = DATA_WIDTH / 8;
    localparam int EMPTY_W = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;

    logic [DATA_WIDTH-1:0] data;
    logic [EMPTY_W-1:0]    empty;
    logic                  sop;
    logic                  eop;
    logic                  vld;
    logic                  rdy;

    modport master (output data, empty, sop, eop, vld, input rdy);
    modport slave  (input data, empty, sop, eop, vld, output rdy);

endinterface

// File: rtl/avst_pkt_gen_word_formatter.sv
// rtl/avst_pkt_gen_word_formatter.sv - combinational builder of one pattern word with eop/empty framing
module avst_pkt_gen_word_formatter
    import avst_gen_pack::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int EMPTY_W    = 2
) (
    input  logic [CNT_WIDTH-1:0]  pkt_idx,
    input  logic [LEN_WIDTH-1:0]  word_off,
    input  logic [LEN_WIDTH-1:0]  remaining,
    output logic [DATA_WIDTH-1:0] data,
    output logic [EMPTY_W-1:0]    empty,
    output logic                  eop
);
    localparam int SYMBOLS = DATA_WIDTH / SYMBOL_WIDTH;

    // Lane 0 is the most-significant byte; lanes past the packet end stay zero.
    always_comb begin
        data = '0;
        for (int i = 0; i < SYMBOLS; i++) begin
            if (32'(remaining) > 32'(i)) begin
                data[DATA_WIDTH-1-SYMBOL_WIDTH*i -: SYMBOL_WIDTH] =
                    pattern_byte(32'(pkt_idx), 32'(word_off) + 32'(i));
            end
        end
        eop   = (32'(remaining) <= 32'(SYMBOLS));
        empty = eop ? EMPTY_W'(32'(SYMBOLS) - 32'(remaining)) : '0;
    end

endmodule

// File: rtl/avst_pkt_gen.sv
// rtl/avst_pkt_gen.sv - Avalon-ST pattern packet source; AVST_PKT_GEN_ERR_INJECT_EN adds periodic eop error flagging
module avst_pkt_gen
    import avst_gen_pack::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int CNT_WIDTH = 16,
    parameter int IPG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    input  logic [CNT_WIDTH-1:0] pkt_num,
    input  logic [IPG_WIDTH-1:0] ipg,
    avalon_st_if.master          src,
    output logic                 out_error,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sent_cnt
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
    ,
    input  logic [CNT_WIDTH-1:0] err_every
`endif
);
    localparam int DW      = $bits(src.data);
    localparam int SYMBOLS = DW / SYMBOL_WIDTH;
    localparam int EMPTY_W = $bits(src.empty);

    gen_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, off_q, off_d;
    logic [CNT_WIDTH-1:0] num_q, num_d, idx_q, idx_d, sent_q, sent_d;
    logic [IPG_WIDTH-1:0] ipg_q, ipg_d, gap_q, gap_d;
    logic                 vld_q, vld_d, sop_q, sop_d, done_q, done_d;
    logic [DW-1:0]        data_q, data_d;
    logic [EMPTY_W-1:0]   empty_q, empty_d;
    logic                 eop_q, eop_d;
    logic                 load, clr;

    logic [DW-1:0]        fmt_data;
    logic [EMPTY_W-1:0]   fmt_empty;
    logic                 fmt_eop;

`ifdef AVST_PKT_GEN_ERR_INJECT_EN
    logic [CNT_WIDTH-1:0] mod_q, mod_d, mod_nx;
    logic                 err_q, err_d;
    assign mod_nx = (mod_q + 1'b1 >= err_every) ? '0 : mod_q + 1'b1;
`endif

    // Formatter sees the next-state counters so the output register loads the upcoming word.
    avst_pkt_gen_word_formatter #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LEN_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .EMPTY_W   (EMPTY_W)
    ) u_fmt (
        .pkt_idx  (idx_d),
        .word_off (off_d),
        .remaining(len_d - off_d),
        .data     (fmt_data),
        .empty    (fmt_empty),
        .eop      (fmt_eop)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        num_d   = num_q;
        ipg_d   = ipg_q;
        idx_d   = idx_q;
        off_d   = off_q;
        gap_d   = gap_q;
        sent_d  = sent_q;
        vld_d   = vld_q;
        sop_d   = sop_q;
        done_d  = 1'b0;
        load    = 1'b0;
        clr     = 1'b0;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
        mod_d   = mod_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && (pkt_len != '0) && (pkt_num != '0)) begin
                    len_d   = pkt_len;
                    num_d   = pkt_num;
                    ipg_d   = ipg;
                    sent_d  = '0;
                    idx_d   = '0;
                    off_d   = '0;
                    load    = 1'b1;
                    vld_d   = 1'b1;
                    sop_d   = 1'b1;
                    state_d = SEND;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
                    mod_d   = '0;
`endif
                end
            end
            SEND: begin
                if (vld_q && src.rdy) begin
                    if (eop_q) begin
                        sent_d = sent_q + 1'b1;
                        if (sent_d == num_q) begin
                            state_d = IDLE;
                            vld_d   = 1'b0;
                            sop_d   = 1'b0;
                            clr     = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            off_d = '0;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
                            mod_d = mod_nx;
`endif
                            if (ipg_q == '0) begin
                                load  = 1'b1;
                                sop_d = 1'b1;
                            end else begin
                                state_d = GAP;
                                gap_d   = ipg_q;
                                vld_d   = 1'b0;
                                sop_d   = 1'b0;
                            end
                        end
                    end else begin
                        off_d = off_q + LEN_WIDTH'(SYMBOLS);
                        load  = 1'b1;
                        sop_d = 1'b0;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q == IPG_WIDTH'(1)) begin
                    load    = 1'b1;
                    vld_d   = 1'b1;
                    sop_d   = 1'b1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        empty_d = empty_q;
        eop_d   = eop_q;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
        err_d   = err_q;
`endif
        if (load) begin
            data_d  = fmt_data;
            empty_d = fmt_empty;
            eop_d   = fmt_eop;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
            err_d   = fmt_eop && (err_every != '0) && (mod_d == err_every - 1'b1);
`endif
        end else if (clr) begin
            data_d  = '0;
            empty_d = '0;
            eop_d   = 1'b0;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            num_q   <= '0;
            ipg_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            gap_q   <= '0;
            sent_q  <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            empty_q <= '0;
            eop_q   <= 1'b0;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
            mod_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            num_q   <= num_d;
            ipg_q   <= ipg_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            gap_q   <= gap_d;
            sent_q  <= sent_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            done_q  <= done_d;
            data_q  <= data_d;
            empty_q <= empty_d;
            eop_q   <= eop_d;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
            mod_q   <= mod_d;
            err_q   <= err_d;
`endif
        end
    end

    assign src.data  = data_q;
    assign src.empty = empty_q;
    assign src.sop   = sop_q;
    assign src.eop   = eop_q;
    assign src.vld   = vld_q;
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
    assign out_error = err_q;
`else
    assign out_error = 1'b0;
`endif
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign sent_cnt  = sent_q;

endmodule

// File: tb/tb_avst_pkt_gen.sv
// tb/tb_avst_pkt_gen.sv - scoreboard bench for avst_pkt_gen with 32-bit data
module tb_avst_pkt_gen;
    import avst_gen_pack::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] pkt_len;
    logic [15:0] pkt_num;
    logic [7:0]  ipg;
    logic        out_error;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;
    logic [15:0] err_every;

    always #5 clk = ~clk;

    avalon_st_if #(.DATA_WIDTH(32)) src_if ();

    avst_pkt_gen #(
        .LEN_WIDTH(16),
        .CNT_WIDTH(16),
        .IPG_WIDTH(8)
    ) dut (
`ifdef AVST_PKT_GEN_ERR_INJECT_EN
        .err_every(err_every),
`endif
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pkt_len  (pkt_len),
        .pkt_num  (pkt_num),
        .ipg      (ipg),
        .src      (src_if),
        .out_error(out_error),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        err;
    } word_t;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    int    exp_ipg = 0;
    int    last_eop_cyc = -10;
    bit    in_gap = 1'b0;
    int    gap_cnt = 0;
    bit    prev_vld = 1'b0;
    bit    prev_rdy = 1'b0;
    word_t prev_word;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp, input logic er);
        exp_q.push_back('{data: d, sop: s, eop: e, empty: emp, err: er});
    endtask

    // Monitor: compares every transfer against the scoreboard and checks hold, gap and done timing.
    always @(negedge clk) begin
        word_t got;
        got = '{data: src_if.data, sop: src_if.sop, eop: src_if.eop, empty: src_if.empty, err: out_error};
        if (!mon_en) begin
            in_gap = 1'b0;
        end else begin
            if (prev_vld && !prev_rdy) begin
                check("hold_vld", 64'(src_if.vld), 64'd1);
                check("hold_word", 64'(got), 64'(prev_word));
            end
            if (in_gap && busy) begin
                if (src_if.vld) begin
                    check("gap_len", 64'(gap_cnt), 64'(exp_ipg));
                    in_gap = 1'b0;
                end else begin
                    gap_cnt++;
                end
            end
            if (done) begin
                check("done_latency", 64'(cyc), 64'(last_eop_cyc + 1));
                in_gap = 1'b0;
            end
            if (src_if.vld && src_if.rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", got);
                end else begin
                    check("word", 64'(got), 64'(exp_q.pop_front()));
                end
                if (src_if.eop) begin
                    last_eop_cyc = cyc;
                    in_gap = 1'b1;
                    gap_cnt = 0;
                end
            end
        end
        prev_vld  = src_if.vld;
        prev_rdy  = src_if.rdy;
        prev_word = got;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [15:0] len, input logic [15:0] num, input logic [7:0] g);
        start = 1'b1;
        pkt_len = len;
        pkt_num = num;
        ipg = g;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [15:0] exp_sent);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 64'(done), 64'd1);
        check({name, "_sent_cnt"}, 64'(sent_cnt), 64'(exp_sent));
        check({name, "_busy_low"}, 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pkt_len = '0;
        pkt_num = '0;
        ipg = '0;
        err_every = '0;
        src_if.rdy = 1'b1;
        repeat (3) tick();
        check("rst_vld", 64'(src_if.vld), 64'd0);
        check("rst_frame", 64'({src_if.sop, src_if.eop, src_if.empty}), 64'd0);
        check("rst_data", 64'(src_if.data), 64'd0);
        check("rst_ctrl", 64'({out_error, busy, done}), 64'd0);
        check("rst_sent", 64'(sent_cnt), 64'd0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // framing: 10 bytes in three 32-bit words
        exp_ipg = 0;
        push(32'h00010203, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h04050607, 1'b0, 1'b0, 2'd0, 1'b0);
        push(32'h08090000, 1'b0, 1'b1, 2'd2, 1'b0);
        start_cmd(16'd10, 16'd1, 8'd0);
        check("frame_busy", 64'(busy), 64'd1);
        check("frame_vld_rise", 64'(src_if.vld), 64'd1);
        wait_done("frame", 16'd1);

        // backpressure on word 1
        push(32'h00010203, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h04050607, 1'b0, 1'b0, 2'd0, 1'b0);
        push(32'h08090000, 1'b0, 1'b1, 2'd2, 1'b0);
        start_cmd(16'd10, 16'd1, 8'd0);
        tick();
        src_if.rdy = 1'b0;
        repeat (5) tick();
        src_if.rdy = 1'b1;
        wait_done("bp", 16'd1);

        // single-word packets back to back
        push(32'h00010203, 1'b1, 1'b1, 2'd0, 1'b0);
        push(32'h01020304, 1'b1, 1'b1, 2'd0, 1'b0);
        start_cmd(16'd4, 16'd2, 8'd0);
        wait_done("single", 16'd2);

        // inter-packet gap, with an ignored start while busy
        exp_ipg = 2;
        push(32'h00010203, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h04050607, 1'b0, 1'b1, 2'd0, 1'b0);
        push(32'h01020304, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h05060708, 1'b0, 1'b1, 2'd0, 1'b0);
        push(32'h02030405, 1'b1, 1'b0, 2'd0, 1'b0);
        push(32'h06070809, 1'b0, 1'b1, 2'd0, 1'b0);
        start_cmd(16'd8, 16'd3, 8'd2);
        tick();
        start_cmd(16'd4, 16'd1, 8'd0);
        wait_done("gap", 16'd3);
        exp_ipg = 0;

        // zero-field starts are ignored
        start_cmd(16'd0, 16'd5, 8'd0);
        check("zero_len_busy", 64'(busy), 64'd0);
        check("zero_len_vld", 64'(src_if.vld), 64'd0);
        start_cmd(16'd4, 16'd0, 8'd0);
        check("zero_num_busy", 64'(busy), 64'd0);

        // reset mid-packet, then a fresh start restarts the pattern
        mon_en = 1'b0;
        start_cmd(16'd10, 16'd1, 8'd0);
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_vld", 64'(src_if.vld), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sent", 64'(sent_cnt), 64'd0);
        check("midrst_data", 64'({src_if.data, src_if.sop, src_if.eop}), 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        mon_en = 1'b1;
        push(32'h00010203, 1'b1, 1'b1, 2'd0, 1'b0);
        start_cmd(16'd4, 16'd1, 8'd0);
        wait_done("restart", 16'd1);

`ifdef AVST_PKT_GEN_ERR_INJECT_EN
        err_every = 16'd2;
        push(32'h00010203, 1'b1, 1'b1, 2'd0, 1'b0);
        push(32'h01020304, 1'b1, 1'b1, 2'd0, 1'b1);
        push(32'h02030405, 1'b1, 1'b1, 2'd0, 1'b0);
        push(32'h03040506, 1'b1, 1'b1, 2'd0, 1'b1);
        start_cmd(16'd4, 16'd4, 8'd0);
        wait_done("errinj", 16'd4);
`endif

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
